reorder_buffer: RTL and testbench

//  In-order retirement queue between issue and the register file. Allocates a

---
 rtl/reorder_buffer_pkg.sv | 34 +++
 rtl/reorder_buffer_if.sv | 69 ++++++
 rtl/reorder_buffer.sv | 193 +++++++++++++++++++
 tb/tb_reorder_buffer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_pkg
// Description : Shared types and constants for the reorder buffer: entry
//               kinds, default geometry, the "no tag" marker and the
//               per-entry record held in the circular queue.
// Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int          ROB_DEPTH = 16;
    localparam int          ROB_TAG_W = 4;
    // Tag value that never matches a real entry; the register file treats a
    // commit carrying it as "nothing to clear".
    localparam logic [31:0] MAXN      = 32'd1000;

    typedef enum logic [1:0] {
        ROB_REG    = 2'd0,
        ROB_STORE  = 2'd1,
        ROB_BRANCH = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic        ready;
        rob_type_e   typ;
        logic [4:0]  rd;
        logic [31:0] value;
        logic        pred;
        logic        taken;
        logic [31:0] target;
    } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_if
// Description : Bundle of every reorder-buffer signal except clock, reset
//               and global enable.
//               issue_*  : allocation request from issue, alloc_tag/rob_full
//                          back to it
//               cdb_*    : result broadcast from the execution units
//               query_*  : two combinational operand lookups by tag
//               commit_* : register-file write of the retiring entry
//               store_*  : permission for the LSB to perform a store
//               clear / redirect_pc : machine flush on a mispredict
//               slave modport = reorder buffer, master modport = pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic        issue_valid;
    rob_type_e   issue_type;
    logic [4:0]  issue_rd;
    logic        issue_pred_taken;
    logic [31:0] alloc_tag;
    logic        rob_full;

    logic        cdb_valid;
    logic [31:0] cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [31:0] cdb_target;

    logic [31:0] query_tag_1;
    logic [31:0] query_tag_2;
    logic        query_ready_1;
    logic        query_ready_2;
    logic [31:0] query_value_1;
    logic [31:0] query_value_2;

    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [31:0] commit_tag;
    logic        store_commit;
    logic [31:0] store_tag;
    logic        clear;
    logic [31:0] redirect_pc;

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pred_taken,
        output alloc_tag, rob_full,
        input  cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        input  query_tag_1, query_tag_2,
        output query_ready_1, query_ready_2, query_value_1, query_value_2,
        output commit_en, commit_rd, commit_value, commit_tag,
        output store_commit, store_tag, clear, redirect_pc
    );

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pred_taken,
        input  alloc_tag, rob_full,
        output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        output query_tag_1, query_tag_2,
        input  query_ready_1, query_ready_2, query_value_1, query_value_2,
        input  commit_en, commit_rd, commit_value, commit_tag,
        input  store_commit, store_tag, clear, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement queue. Allocates the tail entry for each
//               issued instruction (tag = entry index), captures CDB results,
//               and retires at most one ready head entry per cycle through
//               registered single-cycle commit pulses. A retiring branch
//               whose outcome differs from its prediction flushes the queue
//               and raises clear with the correct fetch target.
//   clk_in  : clock
//   rst_in  : synchronous reset, active-high
//   rdy_in  : global enable; low freezes all state and zeroes the pulses
//   rob     : reorder_buffer_if.slave (issue / CDB / query / commit groups)
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int TAG_W = ROB_TAG_W
) (
    input  wire logic           clk_in,
    input  wire logic           rst_in,
    input  wire logic           rdy_in,
    reorder_buffer_if.slave     rob
);

    localparam logic [TAG_W:0] c_full_count = (TAG_W + 1)'(DEPTH);

    rob_entry_t         r_entry [DEPTH];
    logic [TAG_W-1:0]   r_head;
    logic [TAG_W-1:0]   r_tail;
    logic [TAG_W:0]     r_count;

    logic               r_commit_en;
    logic [4:0]         r_commit_rd;
    logic [31:0]        r_commit_value;
    logic [31:0]        r_commit_tag;
    logic               r_store_commit;
    logic [31:0]        r_store_tag;
    logic               r_clear;
    logic [31:0]        r_redirect_pc;

    logic               w_full;
    logic               w_accept;
    logic               w_issue;
    logic               w_cdb_hit;
    logic [TAG_W-1:0]   w_cdb_idx;
    rob_entry_t         w_head_entry;
    logic               w_commit;
    logic               w_mispredict;

    // Full comes from the registered count only, so a commit in the same
    // cycle does not open a slot for issue until the following cycle.
    assign w_full       = (r_count == c_full_count);
    // While clear is high the rest of the machine is still flushing, so
    // issue and CDB traffic from that cycle is stale and dropped.
    assign w_accept     = rdy_in && !r_clear;
    assign w_issue      = w_accept && rob.issue_valid && !w_full;
    // Tags beyond the queue range can never name a live entry.
    assign w_cdb_hit    = w_accept && rob.cdb_valid && (rob.cdb_tag[31:TAG_W] == '0);
    assign w_cdb_idx    = rob.cdb_tag[TAG_W-1:0];
    assign w_head_entry = r_entry[r_head];
    assign w_commit     = rdy_in && (r_count != '0) && w_head_entry.ready;
    assign w_mispredict = w_commit && (w_head_entry.typ == ROB_BRANCH)
                          && (w_head_entry.taken != w_head_entry.pred);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_en    <= 1'b0;
            r_commit_rd    <= 5'd0;
            r_commit_value <= 32'd0;
            r_commit_tag   <= MAXN;
            r_store_commit <= 1'b0;
            r_store_tag    <= MAXN;
            r_clear        <= 1'b0;
            r_redirect_pc  <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i].ready <= 1'b0;
            end
        end else if (rdy_in) begin
            r_commit_en    <= 1'b0;
            r_store_commit <= 1'b0;
            r_clear        <= 1'b0;

            if (w_cdb_hit) begin
                r_entry[w_cdb_idx].ready  <= 1'b1;
                r_entry[w_cdb_idx].value  <= rob.cdb_value;
                r_entry[w_cdb_idx].taken  <= rob.cdb_taken;
                r_entry[w_cdb_idx].target <= rob.cdb_target;
            end

            // Issue is written after the CDB so a fresh allocation always
            // starts not-ready, even if a stale broadcast names its slot.
            if (w_issue) begin
                r_entry[r_tail].ready  <= 1'b0;
                r_entry[r_tail].typ    <= rob.issue_type;
                r_entry[r_tail].rd     <= rob.issue_rd;
                r_entry[r_tail].pred   <= rob.issue_pred_taken;
                r_entry[r_tail].taken  <= 1'b0;
                r_entry[r_tail].value  <= 32'd0;
                r_entry[r_tail].target <= 32'd0;
                r_tail                 <= r_tail + 1'b1;
            end

            if (w_commit) begin
                r_head <= r_head + 1'b1;
                case (w_head_entry.typ)
                    ROB_STORE: begin
                        r_store_commit <= 1'b1;
                        r_store_tag    <= 32'(r_head);
                    end
                    ROB_REG, ROB_BRANCH: begin
                        r_commit_en    <= 1'b1;
                        r_commit_rd    <= w_head_entry.rd;
                        r_commit_value <= w_head_entry.value;
                        r_commit_tag   <= 32'(r_head);
                    end
                    default: ;
                endcase
            end

            case ({w_issue, w_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase

            // The mispredicted branch still writes its link value; every
            // younger entry is discarded on this same edge.
            if (w_mispredict) begin
                r_clear       <= 1'b1;
                r_redirect_pc <= w_head_entry.target;
                r_head        <= '0;
                r_tail        <= '0;
                r_count       <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_entry[i].ready <= 1'b0;
                end
            end
        end else begin
            r_commit_en    <= 1'b0;
            r_store_commit <= 1'b0;
            r_clear        <= 1'b0;
        end
    end

    // Operand lookup: a broadcast in the current cycle is forwarded directly
    // so a consumer need not wait for the entry write.
    always_comb begin
        rob.query_ready_1 = 1'b0;
        rob.query_value_1 = 32'd0;
        if (!r_clear && (rob.query_tag_1[31:TAG_W] == '0)) begin
            if (rob.cdb_valid && (rob.cdb_tag == rob.query_tag_1)) begin
                rob.query_ready_1 = 1'b1;
                rob.query_value_1 = rob.cdb_value;
            end else begin
                rob.query_ready_1 = r_entry[rob.query_tag_1[TAG_W-1:0]].ready;
                rob.query_value_1 = r_entry[rob.query_tag_1[TAG_W-1:0]].value;
            end
        end
    end

    always_comb begin
        rob.query_ready_2 = 1'b0;
        rob.query_value_2 = 32'd0;
        if (!r_clear && (rob.query_tag_2[31:TAG_W] == '0)) begin
            if (rob.cdb_valid && (rob.cdb_tag == rob.query_tag_2)) begin
                rob.query_ready_2 = 1'b1;
                rob.query_value_2 = rob.cdb_value;
            end else begin
                rob.query_ready_2 = r_entry[rob.query_tag_2[TAG_W-1:0]].ready;
                rob.query_value_2 = r_entry[rob.query_tag_2[TAG_W-1:0]].value;
            end
        end
    end

    assign rob.alloc_tag    = 32'(r_tail);
    assign rob.rob_full     = w_full;
    assign rob.commit_en    = r_commit_en;
    assign rob.commit_rd    = r_commit_rd;
    assign rob.commit_value = r_commit_value;
    assign rob.commit_tag   = r_commit_tag;
    assign rob.store_commit = r_store_commit;
    assign rob.store_tag    = r_store_tag;
    assign rob.clear        = r_clear;
    assign rob.redirect_pc  = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Directed self-checking bench for reorder_buffer. Inputs are
//               driven and outputs sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   checks = 0;
    int   errors = 0;

    reorder_buffer_if rob_if ();

    reorder_buffer dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob    (rob_if)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rob_if.issue_valid      = 1'b0;
        rob_if.issue_type       = ROB_REG;
        rob_if.issue_rd         = 5'd0;
        rob_if.issue_pred_taken = 1'b0;
        rob_if.cdb_valid        = 1'b0;
        rob_if.cdb_tag          = 32'd0;
        rob_if.cdb_value        = 32'd0;
        rob_if.cdb_taken        = 1'b0;
        rob_if.cdb_target       = 32'd0;
        rob_if.query_tag_1      = 32'd0;
        rob_if.query_tag_2      = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic set_issue(input rob_type_e t, input logic [4:0] rd, input logic pred);
        rob_if.issue_valid      = 1'b1;
        rob_if.issue_type       = t;
        rob_if.issue_rd         = rd;
        rob_if.issue_pred_taken = pred;
    endtask

    task automatic set_cdb(input logic [31:0] tag, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
        rob_if.cdb_valid  = 1'b1;
        rob_if.cdb_tag    = tag;
        rob_if.cdb_value  = val;
        rob_if.cdb_taken  = taken;
        rob_if.cdb_target = target;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rob_if.rob_full !== 1'b0 || rob_if.alloc_tag !== 32'd0) begin
            errors++;
            $display("FAIL reset_full_tail: full=%b tail=%0d expected 0/0", rob_if.rob_full, rob_if.alloc_tag);
        end
        checks++;
        if (rob_if.commit_en !== 1'b0 || rob_if.store_commit !== 1'b0 || rob_if.clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: en=%b st=%b clr=%b expected 0", rob_if.commit_en, rob_if.store_commit, rob_if.clear);
        end
        checks++;
        if (rob_if.commit_tag !== 32'd1000 || rob_if.store_tag !== 32'd1000) begin
            errors++;
            $display("FAIL reset_tags: commit_tag=%0d store_tag=%0d expected 1000", rob_if.commit_tag, rob_if.store_tag);
        end
        checks++;
        if (rob_if.commit_rd !== 5'd0 || rob_if.commit_value !== 32'd0 || rob_if.redirect_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: rd=%0d val=%0h pc=%0h expected 0", rob_if.commit_rd, rob_if.commit_value, rob_if.redirect_pc);
        end
    endtask

    task automatic test_basic_commit();
        do_reset();
        set_issue(ROB_REG, 5'd5, 1'b0);
        tick();
        idle();
        checks++;
        if (rob_if.alloc_tag !== 32'd1) begin
            errors++;
            $display("FAIL basic_alloc: got %0d expected 1", rob_if.alloc_tag);
        end
        set_cdb(32'd0, 32'h1234, 1'b0, 32'd0);
        tick();
        idle();
        checks++;
        if (rob_if.commit_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_early: commit_en=%b expected 0", rob_if.commit_en);
        end
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b1 || rob_if.commit_rd !== 5'd5 ||
            rob_if.commit_value !== 32'h1234 || rob_if.commit_tag !== 32'd0) begin
            errors++;
            $display("FAIL basic_commit: en=%b rd=%0d val=%0h tag=%0d expected 1/5/1234/0",
                     rob_if.commit_en, rob_if.commit_rd, rob_if.commit_value, rob_if.commit_tag);
        end
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: commit_en=%b expected 0", rob_if.commit_en);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(ROB_REG, 5'(i + 1), 1'b0);
            tick();
        end
        checks++;
        if (rob_if.rob_full !== 1'b1 || rob_if.alloc_tag !== 32'd0) begin
            errors++;
            $display("FAIL full_16: full=%b tail=%0d expected 1/0", rob_if.rob_full, rob_if.alloc_tag);
        end
        tick();
        checks++;
        if (rob_if.rob_full !== 1'b1 || rob_if.alloc_tag !== 32'd0) begin
            errors++;
            $display("FAIL full_17th: full=%b tail=%0d expected 1/0", rob_if.rob_full, rob_if.alloc_tag);
        end
        idle();
        set_cdb(32'd0, 32'h55, 1'b0, 32'd0);
        tick();
        idle();
        // Commit edge with issue pending: issue must still be refused.
        set_issue(ROB_REG, 5'd9, 1'b0);
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b1 || rob_if.commit_tag !== 32'd0 || rob_if.commit_rd !== 5'd1) begin
            errors++;
            $display("FAIL full_commit: en=%b tag=%0d rd=%0d expected 1/0/1", rob_if.commit_en, rob_if.commit_tag, rob_if.commit_rd);
        end
        checks++;
        if (rob_if.rob_full !== 1'b0 || rob_if.alloc_tag !== 32'd0) begin
            errors++;
            $display("FAIL full_release: full=%b tail=%0d expected 0/0", rob_if.rob_full, rob_if.alloc_tag);
        end
        tick();
        checks++;
        if (rob_if.rob_full !== 1'b1 || rob_if.alloc_tag !== 32'd1 || rob_if.commit_en !== 1'b0) begin
            errors++;
            $display("FAIL full_refill: full=%b tail=%0d en=%b expected 1/1/0", rob_if.rob_full, rob_if.alloc_tag, rob_if.commit_en);
        end
        idle();
    endtask

    task automatic test_out_of_order();
        do_reset();
        set_issue(ROB_REG, 5'd3, 1'b0);
        tick();
        set_issue(ROB_REG, 5'd4, 1'b0);
        tick();
        idle();
        set_cdb(32'd1, 32'hB1, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b0) begin
            errors++;
            $display("FAIL ooo_wait1: commit_en=%b expected 0", rob_if.commit_en);
        end
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b0) begin
            errors++;
            $display("FAIL ooo_wait2: commit_en=%b expected 0", rob_if.commit_en);
        end
        set_cdb(32'd0, 32'hA0, 1'b0, 32'd0);
        tick();
        idle();
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b1 || rob_if.commit_tag !== 32'd0 ||
            rob_if.commit_value !== 32'hA0 || rob_if.commit_rd !== 5'd3) begin
            errors++;
            $display("FAIL ooo_tag0: en=%b tag=%0d val=%0h rd=%0d expected 1/0/a0/3",
                     rob_if.commit_en, rob_if.commit_tag, rob_if.commit_value, rob_if.commit_rd);
        end
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b1 || rob_if.commit_tag !== 32'd1 ||
            rob_if.commit_value !== 32'hB1 || rob_if.commit_rd !== 5'd4) begin
            errors++;
            $display("FAIL ooo_tag1: en=%b tag=%0d val=%0h rd=%0d expected 1/1/b1/4",
                     rob_if.commit_en, rob_if.commit_tag, rob_if.commit_value, rob_if.commit_rd);
        end
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b0) begin
            errors++;
            $display("FAIL ooo_done: commit_en=%b expected 0", rob_if.commit_en);
        end
    endtask

    task automatic test_branch();
        do_reset();
        // Correctly predicted branch retires without a flush.
        set_issue(ROB_BRANCH, 5'd1, 1'b1);
        tick();
        idle();
        set_cdb(32'd0, 32'h44, 1'b1, 32'h200);
        tick();
        idle();
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b1 || rob_if.clear !== 1'b0 || rob_if.commit_value !== 32'h44) begin
            errors++;
            $display("FAIL br_predicted: en=%b clr=%b val=%0h expected 1/0/44", rob_if.commit_en, rob_if.clear, rob_if.commit_value);
        end
        // Mispredict: tags 1 (branch) and 2 (younger reg) in flight.
        set_issue(ROB_BRANCH, 5'd0, 1'b0);
        tick();
        set_issue(ROB_REG, 5'd6, 1'b0);
        tick();
        idle();
        set_cdb(32'd1, 32'h0, 1'b1, 32'h100);
        tick();
        idle();
        tick();
        checks++;
        if (rob_if.clear !== 1'b1 || rob_if.redirect_pc !== 32'h100) begin
            errors++;
            $display("FAIL br_clear: clr=%b pc=%0h expected 1/100", rob_if.clear, rob_if.redirect_pc);
        end
        checks++;
        if (rob_if.alloc_tag !== 32'd0 || rob_if.rob_full !== 1'b0) begin
            errors++;
            $display("FAIL br_flush: tail=%0d full=%b expected 0/0", rob_if.alloc_tag, rob_if.rob_full);
        end
        // Clear cycle: issue, CDB and query are all ignored.
        set_issue(ROB_REG, 5'd7, 1'b0);
        set_cdb(32'd2, 32'h99, 1'b0, 32'd0);
        rob_if.query_tag_1 = 32'd2;
        #1;
        checks++;
        if (rob_if.query_ready_1 !== 1'b0) begin
            errors++;
            $display("FAIL br_query_clear: ready=%b expected 0", rob_if.query_ready_1);
        end
        tick();
        rob_if.cdb_valid = 1'b0;
        checks++;
        if (rob_if.clear !== 1'b0 || rob_if.alloc_tag !== 32'd0) begin
            errors++;
            $display("FAIL br_after_clear: clr=%b tail=%0d expected 0/0", rob_if.clear, rob_if.alloc_tag);
        end
        tick();
        idle();
        checks++;
        if (rob_if.alloc_tag !== 32'd1) begin
            errors++;
            $display("FAIL br_reissue: tail=%0d expected 1", rob_if.alloc_tag);
        end
    endtask

    task automatic test_store();
        do_reset();
        set_issue(ROB_REG, 5'd2, 1'b0);
        tick();
        set_issue(ROB_STORE, 5'd0, 1'b0);
        tick();
        idle();
        set_cdb(32'd0, 32'h11, 1'b0, 32'd0);
        tick();
        set_cdb(32'd1, 32'h22, 1'b0, 32'd0);
        tick();
        idle();
        checks++;
        if (rob_if.commit_en !== 1'b1 || rob_if.commit_tag !== 32'd0 || rob_if.store_commit !== 1'b0) begin
            errors++;
            $display("FAIL st_reg_first: en=%b tag=%0d st=%b expected 1/0/0", rob_if.commit_en, rob_if.commit_tag, rob_if.store_commit);
        end
        tick();
        checks++;
        if (rob_if.store_commit !== 1'b1 || rob_if.store_tag !== 32'd1 || rob_if.commit_en !== 1'b0) begin
            errors++;
            $display("FAIL st_commit: st=%b stag=%0d en=%b expected 1/1/0", rob_if.store_commit, rob_if.store_tag, rob_if.commit_en);
        end
        tick();
        checks++;
        if (rob_if.store_commit !== 1'b0 || rob_if.commit_tag !== 32'd0) begin
            errors++;
            $display("FAIL st_pulse: st=%b ctag=%0d expected 0/0", rob_if.store_commit, rob_if.commit_tag);
        end
    endtask

    task automatic test_rdy_and_bypass();
        do_reset();
        set_issue(ROB_REG, 5'd7, 1'b0);
        tick();
        idle();
        set_cdb(32'd0, 32'h77, 1'b0, 32'd0);
        tick();
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rob_if.commit_en !== 1'b0) begin
                errors++;
                $display("FAIL rdy_frozen%0d: commit_en=%b expected 0", i, rob_if.commit_en);
            end
        end
        rdy_in = 1'b1;
        tick();
        checks++;
        if (rob_if.commit_en !== 1'b1 || rob_if.commit_value !== 32'h77 || rob_if.commit_rd !== 5'd7) begin
            errors++;
            $display("FAIL rdy_resume: en=%b val=%0h rd=%0d expected 1/77/7", rob_if.commit_en, rob_if.commit_value, rob_if.commit_rd);
        end
        set_issue(ROB_REG, 5'd8, 1'b0);
        tick();
        idle();
        set_cdb(32'd1, 32'hBEEF, 1'b0, 32'd0);
        rob_if.query_tag_1 = 32'd1;
        rob_if.query_tag_2 = 32'd5;
        #1;
        checks++;
        if (rob_if.query_ready_1 !== 1'b1 || rob_if.query_value_1 !== 32'hBEEF) begin
            errors++;
            $display("FAIL bypass: ready=%b val=%0h expected 1/beef", rob_if.query_ready_1, rob_if.query_value_1);
        end
        checks++;
        if (rob_if.query_ready_2 !== 1'b0) begin
            errors++;
            $display("FAIL query_unready: ready=%b expected 0", rob_if.query_ready_2);
        end
        tick();
        rob_if.cdb_valid   = 1'b0;
        rob_if.query_tag_2 = 32'd1;
        #1;
        checks++;
        if (rob_if.query_ready_2 !== 1'b1 || rob_if.query_value_2 !== 32'hBEEF) begin
            errors++;
            $display("FAIL query_stored: ready=%b val=%0h expected 1/beef", rob_if.query_ready_2, rob_if.query_value_2);
        end
        idle();
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();
        test_reset();
        test_basic_commit();
        test_full();
        test_out_of_order();
        test_branch();
        test_store();
        test_rdy_and_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
